// File: rtl/integral_line_ctrl.sv
// Integral-image line-buffer sequencer: running row sum + previous-row lookup,
// write-back to the line buffer and a valid/ready output register.

// Simple dual-port line buffer: port A writes, port B has a registered read
// that holds its output while enb is low.
module integral_line_buf #(
    parameter int AW = 10,
    parameter int DW = 28
) (
    input  logic          clk,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dina,
    input  logic          enb,
    input  logic [AW-1:0] addrb,
    output logic [DW-1:0] doutb
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write port and registered, enable-held read port
    always_ff @(posedge clk) begin
        if (wea) mem[addra] <= dina;
        if (enb) doutb <= mem[addrb];
    end

endmodule

module integral_line_ctrl #(
    parameter int COL_W = 10,
    parameter int ROW_W = 10,
    parameter int PIX_W = 8,
    parameter int II_W  = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [COL_W:0]   img_width,
    input  logic [ROW_W:0]   img_height,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    output logic             ii_valid,
    output logic [II_W-1:0]  ii_data,
    output logic             ii_eol,
    output logic             ii_eof,
    input  logic             ii_ready,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [COL_W:0] ONE_C = 1;
    localparam logic [ROW_W:0] ONE_R = 1;

    state_t state, state_nxt;

    // latched frame geometry and raster position
    logic [COL_W:0]   width_q;
    logic [ROW_W:0]   height_q;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [II_W-1:0]  row_sum;

    // stage A: pixel accepted, waiting for the line-buffer read data
    logic             a_valid;
    logic [COL_W-1:0] a_col;
    logic [II_W-1:0]  a_sum;
    logic             a_first;
    logic             a_eol;
    logic             a_eof;
    logic             a_byp;
    logic [II_W-1:0]  a_byp_data;

    logic             run_st;
    logic             dim_zero;
    logic             adv;
    logic             accept;
    logic             col_last;
    logic             row_last;
    logic [II_W-1:0]  sum_nxt;
    logic [II_W-1:0]  ram_q;
    logic [II_W-1:0]  prev_row;
    logic [II_W-1:0]  ii_val;
    logic             wr_en;
    logic             byp;

    assign dim_zero = (width_q == '0) || (height_q == '0);
    assign adv      = !ii_valid || ii_ready;
    // a zero-sized frame passes through RUN for one cycle without taking pixels
    assign pix_ready = run_st && adv && !dim_zero;
    assign accept   = pix_valid && pix_ready;

    assign col_last = ({1'b0, col} == (width_q - ONE_C));
    assign row_last = ({1'b0, row} == (height_q - ONE_R));
    assign sum_nxt  = ((col == '0) ? '0 : row_sum) + {{(II_W-PIX_W){1'b0}}, pix_data};

    assign prev_row = a_byp ? a_byp_data : ram_q;
    assign ii_val   = a_sum + (a_first ? '0 : prev_row);
    assign wr_en    = a_valid && adv;
    // a read that coincides with a write to the same column (width 1) would
    // return the old word, so the written value is captured alongside stage A
    assign byp      = wr_en && (a_col == col);

    integral_line_buf #(
        .AW(COL_W),
        .DW(II_W)
    ) u_line_buf (
        .clk   (clk),
        .wea   (wr_en),
        .addra (a_col),
        .dina  (ii_val),
        .enb   (accept),
        .addrb (col),
        .doutb (ram_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                if (dim_zero)               state_nxt = DONE;
                else if (accept && col_last && row_last) state_nxt = DRAIN;
            end
            DRAIN: if (!a_valid && adv) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        run_st     = 1'b0;
        case (state)
            IDLE:  ;
            RUN:   begin busy = 1'b1; run_st = 1'b1; end
            DRAIN: busy = 1'b1;
            DONE:  begin busy = 1'b1; frame_done = 1'b1; end
            default: ;
        endcase
    end

    // Geometry latch, raster counters and running row sum
    always_ff @(posedge clk) begin
        if (rst) begin
            width_q  <= '0;
            height_q <= '0;
            col      <= '0;
            row      <= '0;
            row_sum  <= '0;
        end else if (state == IDLE && start) begin
            width_q  <= img_width;
            height_q <= img_height;
            col      <= '0;
            row      <= '0;
        end else if (accept) begin
            row_sum <= sum_nxt;
            if (col_last) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Stage A: load on accept, clear when retired without a replacement
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
        end else if (accept) begin
            a_valid    <= 1'b1;
            a_col      <= col;
            a_sum      <= sum_nxt;
            a_first    <= (row == '0);
            a_eol      <= col_last;
            a_eof      <= col_last && row_last;
            a_byp      <= byp;
            a_byp_data <= ii_val;
        end else if (adv) begin
            a_valid <= 1'b0;
        end
    end

    // Output register: advances whenever it is empty or being consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            ii_valid <= 1'b0;
            ii_data  <= '0;
            ii_eol   <= 1'b0;
            ii_eof   <= 1'b0;
        end else if (adv) begin
            ii_valid <= a_valid;
            if (a_valid) begin
                ii_data <= ii_val;
                ii_eol  <= a_eol;
                ii_eof  <= a_eof;
            end
        end
    end

endmodule
